// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Produces per-cycle write-enable/flush controls for PC, IF/ID, ID/EX, EX/MEM
// and MEM/WB from cache hits, load-use hazards, redirects and HALT.
// Optional performance counters are built when PIPECTL_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        exmem_redirect,
  input  logic        exmem_halt,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  output logic        pcWEN,
  output logic        ifid_writeEN,
  output logic        idex_writeEN,
  output logic        exmem_writeEN,
  output logic        memwb_writeEN,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   halt_q, halt_d;
  logic   dacc;
  logic   lu;
  logic   adv;

  assign dacc = exmem_dREN | exmem_dWEN;
  assign lu   = idex_dREN & (idex_rt != 5'd0) &
                ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Next state and latch controls. DWAIT releases into the same decision
  // tree as RUN so a completed data access resolves hazards in that cycle.
  always_comb begin
    pcWEN         = 1'b0;
    ifid_writeEN  = 1'b0;
    idex_writeEN  = 1'b0;
    exmem_writeEN = 1'b0;
    memwb_writeEN = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    state_d       = state_q;
    adv           = 1'b0;

    case (state_q)
      RUN: begin
        adv = ~dacc | dhit;
        if (!adv) state_d = DWAIT;
      end
      DWAIT: begin
        // dhit only counts when MEM actually holds an access
        adv = dacc & dhit;
      end
      DRAIN: begin
        memwb_writeEN = 1'b1;
        state_d       = HALTED;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (adv) begin
      exmem_writeEN = 1'b1;
      memwb_writeEN = 1'b1;
      state_d       = RUN;
      if (exmem_halt) begin
        ifid_writeEN = 1'b1;
        idex_writeEN = 1'b1;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_flush  = 1'b1;
        state_d      = DRAIN;
      end else if (exmem_redirect) begin
        pcWEN        = 1'b1;
        ifid_writeEN = 1'b1;
        idex_writeEN = 1'b1;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_flush  = 1'b1;
      end else if (lu || !ihit) begin
        idex_writeEN = 1'b1;
        idex_flush   = 1'b1;
      end else begin
        pcWEN        = 1'b1;
        ifid_writeEN = 1'b1;
        idex_writeEN = 1'b1;
      end
    end
  end

  // Registered halt follows the state being entered.
  always_comb begin
    halt_d = (state_d == HALTED);
  end

  // State and halt flag registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign halt = halt_q;

`ifdef PIPECTL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]  flush_n;
  logic [32:0] flush_sum;

  // Counter updates: saturating, frozen once halted.
  always_comb begin
    flush_n = {1'b0, ifid_flush & ifid_writeEN} +
              {1'b0, idex_flush & idex_writeEN} +
              {1'b0, exmem_flush & exmem_writeEN};
    flush_sum   = {1'b0, flush_cnt_q} + {31'b0, flush_n};
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALTED) begin
      if (!pcWEN && (state_q == RUN || state_q == DWAIT) && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 32'd1;
      flush_cnt_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
